// File: rtl/coreaxitoahbl_pkg.sv
// Shared CoreAXItoAHBL definitions: HSIZE codes, splitter state encoding, clog2 helper.
package coreaxitoahbl_pkg;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_QWORD = 3'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/coreaxitoahbl_wstrb_chunk.sv
// Combinational chunk finder: lowest set strobe bit, largest aligned all-ones run at it, and last flag.
module coreaxitoahbl_wstrb_chunk #(
  parameter int unsigned STRB_W = 8,
  parameter int unsigned OFF_W  = 3,
  parameter int unsigned MAX_S  = 3
) (
  input  logic [STRB_W-1:0] mask_i,
  output logic [OFF_W-1:0]  offset_o,
  output logic [2:0]        size_o,
  output logic [STRB_W-1:0] chunk_o,
  output logic              last_o
);

  logic [STRB_W-1:0] cand;
  logic              grow;

  always_comb begin
    offset_o = '0;
    size_o   = 3'd0;
    cand     = '0;
    grow     = 1'b1;
    for (int i = int'(STRB_W) - 1; i >= 0; i--) begin
      if (mask_i[i]) offset_o = OFF_W'(i);
    end
    chunk_o = mask_i & (STRB_W'(1) << offset_o);
    // Alignment and contiguity both nest, so stop growing at the first failing size.
    for (int k = 1; k <= int'(MAX_S); k++) begin
      cand = STRB_W'((1 << (1 << k)) - 1) << offset_o;
      if (grow && ((int'(offset_o) & ((1 << k) - 1)) == 0) &&
          ((int'(offset_o) + (1 << k)) <= int'(STRB_W)) && ((mask_i & cand) == cand)) begin
        size_o  = 3'(k);
        chunk_o = cand;
      end else begin
        grow = 1'b0;
      end
    end
    last_o = ((mask_i & ~chunk_o) == '0);
  end

endmodule

// File: rtl/coreaxitoahbl_wstrb_splitter.sv
// Splits one AXI write beat's strobe into naturally aligned AHB transfers, one per handshake.
// Optional COREAXITOAHBL_ZERO_STRB_XFER_EN: all-zero strobe emits a single null descriptor (xferNull).
module coreaxitoahbl_wstrb_splitter
  import coreaxitoahbl_pkg::*;
#(
  parameter int unsigned AXI_DWIDTH    = 64,
  parameter int unsigned AXI_STRBWIDTH = AXI_DWIDTH / 8,
  parameter int unsigned OFFSET_WIDTH  = clog2(AXI_STRBWIDTH),
  parameter int unsigned MAX_HSIZE     = 3
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [AXI_STRBWIDTH-1:0] WSTRBIn,
  input  logic                     beatValid,
  output logic                     beatReady,
  output logic                     xferValid,
  input  logic                     xferReady,
  output logic [OFFSET_WIDTH-1:0]  xferOffset,
  output logic [2:0]               xferSize,
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
  output logic                     xferNull,
`endif
  output logic                     xferLast
);

  localparam int unsigned SIZE_LIM = (MAX_HSIZE < OFFSET_WIDTH) ? MAX_HSIZE : OFFSET_WIDTH;

  split_state_t             state_q, state_d;
  logic [AXI_STRBWIDTH-1:0] rem_mask_q, rem_mask_d;
  logic                     null_q, null_d;

  logic [OFFSET_WIDTH-1:0]  ck_offset;
  logic [2:0]               ck_size;
  logic [AXI_STRBWIDTH-1:0] ck_chunk;
  logic                     ck_last;
  logic                     in_split;
  logic                     accept;

  coreaxitoahbl_wstrb_chunk #(
    .STRB_W (AXI_STRBWIDTH),
    .OFF_W  (OFFSET_WIDTH),
    .MAX_S  (SIZE_LIM)
  ) u_chunk (
    .mask_i   (rem_mask_q),
    .offset_o (ck_offset),
    .size_o   (ck_size),
    .chunk_o  (ck_chunk),
    .last_o   (ck_last)
  );

  // Descriptor is a pure decode of the registered state and remaining mask.
  assign in_split   = (state_q == ST_SPLIT);
  assign xferValid  = in_split;
  assign xferOffset = in_split ? ck_offset : '0;
  assign xferSize   = in_split ? ck_size : HSIZE_BYTE;
  assign xferLast   = in_split && ck_last;
  assign beatReady  = !in_split || (ck_last && xferReady);
  assign accept     = beatValid && beatReady;
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
  assign xferNull   = in_split && null_q;
`endif

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    null_d     = null_q;
    if (in_split && xferReady) begin
      rem_mask_d = rem_mask_q & ~ck_chunk;
      null_d     = 1'b0;
      if (ck_last) state_d = ST_IDLE;
    end
    // New beat: covers both IDLE acceptance and back-to-back acceptance on the last transfer.
    if (accept) begin
      rem_mask_d = WSTRBIn;
      null_d     = 1'b0;
      if (WSTRBIn != '0) begin
        state_d = ST_SPLIT;
      end else begin
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
        state_d = ST_SPLIT;
        null_d  = 1'b1;
`else
        state_d = ST_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
      null_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      null_q     <= null_d;
    end
  end

`ifndef COREAXITOAHBL_ZERO_STRB_XFER_EN
  logic unused_null;
  assign unused_null = null_q;
`endif

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_splitter.sv
// Directed self-checking bench for coreaxitoahbl_wstrb_splitter at AXI_DWIDTH=64, MAX_HSIZE=3.
module tb_coreaxitoahbl_wstrb_splitter;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] strb;
  logic       bvalid;
  logic       bready;
  logic       xvalid;
  logic       xready;
  logic [2:0] xoff;
  logic [2:0] xsize;
  logic       xlast;
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
  logic       xnull;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  coreaxitoahbl_wstrb_splitter #(
    .AXI_DWIDTH (64),
    .MAX_HSIZE  (3)
  ) dut (
    .ACLK       (clk),
    .ARESET     (arst),
    .WSTRBIn    (strb),
    .beatValid  (bvalid),
    .beatReady  (bready),
    .xferValid  (xvalid),
    .xferReady  (xready),
    .xferOffset (xoff),
    .xferSize   (xsize),
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
    .xferNull   (xnull),
`endif
    .xferLast   (xlast)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full snapshot of the outward-facing descriptor and handshake.
  task automatic chk_x(input string tag, input logic v, input logic [2:0] off,
                       input logic [2:0] sz, input logic last, input logic br);
    chk({tag, ".valid"}, 8'(xvalid), 8'(v));
    chk({tag, ".beatReady"}, 8'(bready), 8'(br));
    if (v) begin
      chk({tag, ".offset"}, 8'(xoff), 8'(off));
      chk({tag, ".size"}, 8'(xsize), 8'(sz));
      chk({tag, ".last"}, 8'(xlast), 8'(last));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1; strb = 8'h00; bvalid = 1'b0; xready = 1'b1;
    tick(); tick();
    arst = 1'b0;
    tick(); settle();
    chk("rst.valid", 8'(xvalid), 8'd0);
    chk("rst.beatReady", 8'(bready), 8'd1);
    chk("rst.offset", 8'(xoff), 8'd0);
    chk("rst.size", 8'(xsize), 8'd0);
    chk("rst.last", 8'(xlast), 8'd0);

    // 1: full strobe -> single doubleword
    bvalid = 1'b1; strb = 8'hFF; settle();
    chk("t1.accept_ready", 8'(bready), 8'd1);
    tick(); bvalid = 1'b0; settle();
    chk_x("t1.x0", 1'b1, 3'd0, 3'd3, 1'b1, 1'b1);
    tick(); settle();
    chk_x("t1.done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 2: unaligned run splits into byte/half/half/byte
    bvalid = 1'b1; strb = 8'b0111_1110;
    tick(); bvalid = 1'b0; settle();
    chk_x("t2.x0", 1'b1, 3'd1, 3'd0, 1'b0, 1'b0);
    tick(); settle();
    chk_x("t2.x1", 1'b1, 3'd2, 3'd1, 1'b0, 1'b0);
    tick(); settle();
    chk_x("t2.x2", 1'b1, 3'd4, 3'd1, 1'b0, 1'b0);
    tick(); settle();
    chk_x("t2.x3", 1'b1, 3'd6, 3'd0, 1'b1, 1'b1);
    tick(); settle();
    chk_x("t2.done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 3: stall holds the descriptor; a beat offered meanwhile is not taken
    bvalid = 1'b1; strb = 8'hF0;
    tick(); xready = 1'b0; strb = 8'h01; settle();
    for (int i = 0; i < 5; i++) begin
      chk_x("t3.stall", 1'b1, 3'd4, 3'd2, 1'b1, 1'b0);
      tick(); settle();
    end
    bvalid = 1'b0; xready = 1'b1; settle();
    chk_x("t3.go", 1'b1, 3'd4, 3'd2, 1'b1, 1'b1);
    tick(); settle();
    chk_x("t3.nodup", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 4: back-to-back beats, no bubble
    bvalid = 1'b1; strb = 8'h0F;
    tick(); strb = 8'hC0; settle();
    chk_x("t4.x0", 1'b1, 3'd0, 3'd2, 1'b1, 1'b1);
    tick(); bvalid = 1'b0; settle();
    chk_x("t4.x1", 1'b1, 3'd6, 3'd1, 1'b1, 1'b1);
    tick(); settle();
    chk_x("t4.done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 5: reset mid-split drops the remaining bytes
    bvalid = 1'b1; strb = 8'b0101_0101;
    tick(); bvalid = 1'b0; settle();
    chk_x("t5.x0", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(); settle();
    chk_x("t5.x1", 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
    arst = 1'b1;
    tick(); arst = 1'b0; settle();
    chk_x("t5.rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    tick(); settle();
    chk_x("t5.quiet", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 6: zero strobe
    bvalid = 1'b1; strb = 8'h00; settle();
    chk("t6.accept_ready", 8'(bready), 8'd1);
    tick(); bvalid = 1'b0; settle();
`ifdef COREAXITOAHBL_ZERO_STRB_XFER_EN
    chk_x("t6.null", 1'b1, 3'd0, 3'd0, 1'b1, 1'b1);
    chk("t6.xferNull", 8'(xnull), 8'd1);
    tick(); settle();
    chk_x("t6.done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
`else
    chk_x("t6.silent", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    tick(); settle();
    chk_x("t6.silent2", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
`endif

    // 7: alternating bytes give the maximum transfer count
    bvalid = 1'b1; strb = 8'b1010_1010;
    tick(); bvalid = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      chk_x("t7.byte", 1'b1, 3'(2 * i + 1), 3'd0, (i == 3), (i == 3));
      tick(); settle();
    end
    chk_x("t7.done", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
